// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and default constants for the run controller
package run_ctrl_pkg;

    localparam int RUN_CW      = 16;
    localparam int RUN_RST_CYC = 2;
    localparam int RUN_TIMEOUT = 4000;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        REQ,
        RUN,
        FIN
    } run_state_t;

endpackage

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - CW-bit up counter with clear, enable and terminal-count compare
module cycle_counter
    import run_ctrl_pkg::*;
#(
    parameter int CW = RUN_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          tc
);

    // Clear has priority over enable so a new run always starts from zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - core run controller: reset hold, request pulse, cycle count and timeout
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CW      = RUN_CW,
    parameter int RST_CYC = RUN_RST_CYC,
    parameter int TIMEOUT = RUN_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycles
);

    localparam logic [3:0]    HOLD_LAST = 4'(RST_CYC - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    run_state_t state;
    run_state_t state_nxt;
    logic [3:0] hold_cnt;
    logic       accept;
    logic       run_live;
    logic       cnt_tc;

    assign accept   = (state == IDLE) && start;
    // A RUN cycle without done counts; the timeout cycle also counts, landing on TIMEOUT
    assign run_live = (state == RUN) && !core_done;

    cycle_counter #(
        .CW(CW)
    ) u_cycles (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .en   (run_live),
        .limit(CNT_LIMIT),
        .count(cycles),
        .tc   (cnt_tc)
    );

    // State register; async clear re-parks the core immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        core_reset = 1'b1;
        core_req   = 1'b0;
        busy       = 1'b1;
        finished   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                core_reset = 1'b0;
                core_req   = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                core_reset = 1'b0;
                if (core_done || cnt_tc) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                finished  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Hold counter paces how long the core stays in reset after start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (accept) begin
            hold_cnt <= '0;
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Sticky timeout flag; done in the same cycle as the limit wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timed_out <= 1'b0;
        end else if (accept) begin
            timed_out <= 1'b0;
        end else if (run_live && cnt_tc) begin
            timed_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - self-checking bench for run_ctrl with a run-level reference model
module tb_run_ctrl;

    localparam int CW = 16;
    localparam int RC = 2;
    localparam int TO = 150;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          core_done = 1'b0;
    logic          core_reset;
    logic          core_req;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycles;

    always #5 clk = ~clk;

    run_ctrl #(
        .CW     (CW),
        .RST_CYC(RC),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .core_done (core_done),
        .core_reset(core_reset),
        .core_req  (core_req),
        .busy      (busy),
        .finished  (finished),
        .timed_out (timed_out),
        .cycles    (cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a run is described by the period index that accepted it
    // (m_n) and the period index of its FIN (m_end, -1 while still open).
    int edge_n   = 0;
    int m_prev   = 0;
    bit m_active = 1'b0;
    int m_n      = 0;
    int m_end    = -1;
    int m_cycles = 0;
    bit m_to     = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_active = 1'b0;
                m_end    = -1;
                m_cycles = 0;
                m_to     = 1'b0;
            end else begin
                m_prev = edge_n;
                edge_n = edge_n + 1;
                if (m_active && m_prev == m_end) begin
                    m_active = 1'b0;
                end else if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1;
                        m_n      = edge_n;
                        m_end    = -1;
                        m_cycles = 0;
                        m_to     = 1'b0;
                    end
                end else if (m_end < 0 && m_prev >= m_n + RC + 1) begin
                    if (core_done) begin
                        m_end = edge_n;
                    end else if (m_cycles == TO - 1) begin
                        m_cycles = TO;
                        m_to     = 1'b1;
                        m_end    = edge_n;
                    end else begin
                        m_cycles = m_cycles + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        int off;
        bit er, eq, eb, ef;
        off = edge_n - m_n;
        er = 1'b1; eq = 1'b0; eb = 1'b0; ef = 1'b0;
        if (m_active) begin
            eb = 1'b1;
            if (m_end >= 0 && edge_n == m_end) begin
                ef = 1'b1;
            end else if (off == RC) begin
                er = 1'b0;
                eq = 1'b1;
            end else if (off > RC) begin
                er = 1'b0;
            end
        end
        check("m_core_reset", int'(core_reset), int'(er));
        check("m_core_req", int'(core_req), int'(eq));
        check("m_busy", int'(busy), int'(eb));
        check("m_finished", int'(finished), int'(ef));
        check("m_timed_out", int'(timed_out), int'(m_to));
        check("m_cycles", int'(cycles), m_cycles);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cmp_model();
    endtask

    // Accept a start and advance to the first RUN period
    task automatic to_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RC + 1) tick();
    endtask

    int k;
    int dmod;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst_core_reset", int'(core_reset), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_cycles", int'(cycles), 0);
        check("rst_timed_out", int'(timed_out), 0);
        check("rst_core_req", int'(core_req), 0);
        cmp_model();
        reset = 1'b1;
        repeat (10) tick();
        check("idle_busy", int'(busy), 0);

        // Start-to-request latency, with start and done poked during HOLD
        start = 1'b1;
        tick();
        start = 1'b1;
        core_done = 1'b1;
        check("lat_hold0_busy", int'(busy), 1);
        check("lat_hold0_rst", int'(core_reset), 1);
        tick();
        start = 1'b0;
        core_done = 1'b0;
        check("lat_hold1_rst", int'(core_reset), 1);
        check("lat_hold1_req", int'(core_req), 0);
        tick();
        check("lat_req", int'(core_req), 1);
        check("lat_req_rst", int'(core_reset), 0);
        tick();
        check("run1_req", int'(core_req), 0);
        check("run1_cycles", int'(cycles), 0);

        // Normal completion on the 130th RUN cycle, start pulsed mid-run and in FIN
        for (int i = 0; i < 129; i++) begin
            start = (i == 50);
            tick();
        end
        start = 1'b0;
        check("norm_pre_cycles", int'(cycles), 129);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("norm_fin", int'(finished), 1);
        check("norm_cycles", int'(cycles), 129);
        check("norm_to", int'(timed_out), 0);
        check("norm_fin_rst", int'(core_reset), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fin_start_ignored", int'(busy), 0);
        check("fin_cycles_held", int'(cycles), 129);
        tick();

        // Timeout: finished TO periods after the first RUN period
        to_run();
        k = 0;
        while (!finished && k < TO + 10) begin
            tick();
            k++;
        end
        check("to_latency", k, TO);
        check("to_cycles", int'(cycles), TO);
        check("to_flag", int'(timed_out), 1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_clear", int'(timed_out), 0);
        check("to_cycles_clear", int'(cycles), 0);

        // Simultaneous done and timeout resolves as done
        repeat (RC + 1) tick();
        repeat (TO - 1) tick();
        check("sim_pre_cycles", int'(cycles), TO - 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("sim_fin", int'(finished), 1);
        check("sim_to", int'(timed_out), 0);
        check("sim_cycles", int'(cycles), TO - 1);
        tick();

        // Abort mid-RUN
        to_run();
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("abort_rst", int'(core_reset), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_req", int'(core_req), 0);
        check("abort_fin", int'(finished), 0);
        check("abort_cycles", int'(cycles), 0);
        check("abort_to", int'(timed_out), 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Randomized traffic against the model
        dmod = 15;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) dmod = (dmod == 15) ? 400 : 15;
            start = ($urandom_range(0, 7) == 0);
            core_done = ($urandom_range(0, dmod) == 0);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                #1;
                cmp_model();
                tick();
                reset = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        core_done = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
